// File: rtl/iterative_divider.sv
// Restoring unsigned divider: one quotient bit per clock, WIDTH cycles per operation.
// Handshake: start is accepted only in IDLE; done pulses once when quotient/remainder are valid.
module iterative_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_sub;
  logic             w_borrow;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;

  // Partial remainder is WIDTH+1 bits so large divisors cannot overflow the trial subtract.
  assign w_shift  = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_sub    = {1'b0, w_shift} - {2'b00, r_div};
  assign w_borrow = w_sub[WIDTH+1];
  assign w_r_next = w_borrow ? w_shift : w_sub[WIDTH:0];
  assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (divisor == '0) ? S_FINISH : S_RUN;
      S_RUN:    if (w_last) w_next = S_FINISH;
      S_FINISH: if (r_done) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      r_div  <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_div  <= divisor;
            r_q    <= dividend;
            r_r    <= '0;
            r_cnt  <= CW'(WIDTH);
            r_busy <= 1'b1;
            r_dbz  <= 1'b0;
          end
        end
        S_RUN: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_quot <= w_q_next;
            r_rem  <= w_r_next[WIDTH-1:0];
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        S_FINISH: begin
          // Entered with done low only on the zero-divisor path: publish the result now.
          if (r_done) begin
            r_done <= 1'b0;
          end else begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_quot <= '1;
            r_rem  <= r_q;
            r_dbz  <= 1'b1;
          end
        end
        default: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed cases plus random operands
// scored against plain arithmetic division.
module tb_iterative_divider;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_acc   = 0;

  logic [2*W:0] exp_q[$];
  int           dc_q[$];
  logic [2*W:0] mon_e;
  int           mon_d;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;
  bit           have_last = 1'b0;

  iterative_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: {div_by_zero, quotient, remainder}
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, a / b, a % b};
  endfunction

  // driver tasks
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    int guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("idle_timeout", 1, 0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    t_acc = cyc;
    if (!hold) start = 1'b0;
    exp_q.push_back(model(a, b));
    dc_q.push_back(t_acc + ((b == '0) ? 1 : W));
    @(negedge clk);
    check("busy_after_start", W'(busy), 1);
    check("dbz_cleared", W'(div_by_zero), 0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("done_timeout", W'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("extra_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_d = dc_q.pop_front();
          check("quotient", quotient, mon_e[2*W-1:W]);
          check("remainder", remainder, mon_e[W-1:0]);
          check("div_by_zero", W'(div_by_zero), W'(mon_e[2*W]));
          check("done_cycle", W'(cyc), W'(mon_d));
          check("busy_at_done", W'(busy), 0);
          last_q = mon_e[2*W-1:W];
          last_r = mon_e[W-1:0];
        end
      end else if (have_last) begin
        check("hold_quotient", quotient, last_q);
        check("hold_remainder", remainder, last_r);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int t0;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", W'(div_by_zero), 0);
    last_q    = '0;
    last_r    = '0;
    have_last = 1'b1;
    reset     = 1'b0;

    launch(64'd100, 64'd7, 1'b0);
    wait_idle();
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);
    wait_idle();
    launch(64'd5, 64'd9, 1'b0);
    wait_idle();
    launch(64'd1234, 64'd0, 1'b0);
    wait_idle();
    check("dbz_held", W'(div_by_zero), 1);
    launch(64'd10, 64'd3, 1'b0);
    wait_idle();
    launch(64'd0, 64'd17, 1'b0);
    wait_idle();
    launch(64'hDEAD_BEEF_0123_4567, 64'd1, 1'b0);
    wait_idle();

    // second request while running must be ignored
    launch(64'd100, 64'd7, 1'b0);
    repeat (9) @(negedge clk);
    start    = 1'b1;
    dividend = 64'd50;
    divisor  = 64'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // reset mid-operation discards the result
    launch(64'd100, 64'd7, 1'b0);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    dc_q.delete();
    @(posedge clk);
    #1;
    check("midrst_busy", W'(busy), 0);
    check("midrst_done", W'(done), 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    last_q = '0;
    last_r = '0;
    reset  = 1'b0;
    repeat (80) @(negedge clk);
    launch(64'd9, 64'd3, 1'b0);
    wait_idle();

    // start held high: one acceptance per 66 cycles
    launch(64'd21, 64'd4, 1'b1);
    t0 = t_acc;
    exp_q.push_back(model(64'd21, 64'd4));
    dc_q.push_back(t0 + W + 2 + W);
    exp_q.push_back(model(64'd21, 64'd4));
    dc_q.push_back(t0 + 2 * (W + 2) + W);
    while (cyc < t0 + 2 * (W + 2) + W) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // random operands, with zero and one divisors mixed in
    for (int i = 0; i < 24; i++) begin
      a = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 64'd1;
        2:       b = a + 64'd1;
        default: b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      endcase
      launch(a, b, 1'b0);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
